router_controller_np: RTL and testbench
=======================================

# router_controller_np

Parametrised N-port router controller for the Aurora router datapath. It serves NUM_PORTS input FIFOs in round-robin order and pops one 64-bit flit at a time. For each flit it decodes the header and decides between local delivery, TTL-decremented forwarding to the other ports, or a drop. It then drives a shared output word plus a per-port write mask into the output FIFOs, with backpressure from their full flags. Port 0 is the local (encode/decode) port; ports 1..NUM_PORTS-1 are Aurora links.

## Interface
- AURORA_DATA_WIDTH, 64, flit width
- NUM_PORTS, 4, number of input/output port pairs (2..8)
- RECOGNIZE_ROUTER_WIDTH, 2, router-ID field width
- ROUTER_ID, 0, this router's ID
- TTL_LSB, 7, LSB of the 2-bit TTL field (bits [TTL_LSB+1:TTL_LSB])
- DST_LSB, 9, LSB of the destination router-ID field
- PW = $clog2(NUM_PORTS) (localparam)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_empty  in  NUM_PORTS  input FIFO empty flags
- in_rd  out  NUM_PORTS  input FIFO pop, one-hot, 1-cycle pulse
- in_data  in  NUM_PORTS*AURORA_DATA_WIDTH  FIFO read data, port p at [p*W +: W], valid the cycle after in_rd
- out_full  in  NUM_PORTS  output FIFO full flags
- out_we  out  NUM_PORTS  output FIFO write mask
- out_data  out  AURORA_DATA_WIDTH  flit broadcast to all output FIFOs
- grant_port  out  PW  port currently being served
- busy  out  1  high whenever state != IDLE
- pkt_dropped  out  1  1-cycle pulse per dropped flit
- drop_count  out  16  saturating drop counter

## Operation
- FSM states: IDLE, READ, HEADER, WRITE.
- IDLE: if any in_empty bit is 0, pick the winner by round-robin, latch it to grant_port, go to READ. Otherwise stay in IDLE.
- Round-robin search starts at (last_grant+1) mod NUM_PORTS. last_grant resets to NUM_PORTS-1, so port 0 has first priority after reset.
- READ: in_rd[grant_port]=1 for exactly this cycle, then go to HEADER.
- HEADER: register in_data[grant_port]. Extract ttl and dst, compute mask and outgoing word:
  - dst==ROUTER_ID and grant_port!=0: mask = bit 0 only; word unchanged.
  - dst==ROUTER_ID and grant_port==0: drop (local loopback is illegal).
  - dst!=ROUTER_ID and ttl>1: mask = all ones, minus bit 0, minus bit grant_port; TTL field = ttl-1; all other bits unchanged.
  - dst!=ROUTER_ID and ttl<=1: drop.
  - mask==0 after the rules above: drop.
- On any drop: pulse pkt_dropped, increment drop_count (saturate at 16'hFFFF), update last_grant, and go to IDLE.
- Otherwise go to WRITE.
- WRITE:
  - If (mask & out_full)==0: out_we=mask for one cycle, update last_grant, then leave.
    - Go to READ directly if another port is non-empty, re-arbitrating with the updated pointer in the same cycle.
    - Go to IDLE otherwise.
  - Else stall with out_we=0 and out_data held. All-or-nothing: no partial writes.
- out_data is the registered modified word. It is stable from the cycle after HEADER until leaving WRITE.
- A flit is never written back to the port it arrived on. Local-port ingress is never delivered to port 0.

## Timing
- Reset values: in_rd=0, out_we=0, out_data=0, grant_port=0, busy=0, pkt_dropped=0, drop_count=0, state=IDLE, last_grant=NUM_PORTS-1.
- in_rd and out_we are decoded combinationally from state/registers and are glitch-free per cycle.
- Unstalled latency: cycle 0 IDLE sees non-empty → cycle 1 READ (in_rd) → cycle 2 HEADER → cycle 3 WRITE (out_we).
- Sustained throughput: one flit per 3 cycles (READ, HEADER, WRITE).
- A full flag asserted in the same cycle as WRITE is honoured: no write that cycle.
- A drop pulses pkt_dropped in the HEADER cycle; the FSM returns to IDLE next cycle.
- in_empty changes during READ/HEADER/WRITE do not affect the current flit.
- rst_n asserted mid-flit: everything returns to reset values immediately; the in-flight flit is lost, with no write and no drop count.

## Test plan
- Reset, then a flit arrives on port 2 with dst=0, ttl=2 (ROUTER_ID=0) → in_rd=4'b0100 at cycle 1, out_we=4'b0001 at cycle 3, out_data identical to the input.
- A port 0 flit with dst=3, ttl=3, all out_full=0 → out_we=4'b1110, out_data TTL field=2'b10, other bits unchanged.
- A port 1 flit with dst=2, ttl=1 → no out_we, one pkt_dropped pulse, drop_count=1. A second flit with ttl=0 → drop_count=2.
- Ports 0, 1 and 3 all non-empty from reset → grant order 0,1,3,0,…, with back-to-back READ after each WRITE (no IDLE cycle).
- A port 1 flit with dst=3, ttl=3, out_full=4'b0100 held for 5 cycles → WRITE stalls 5 cycles with out_data stable, then out_we=4'b1100 once.
- rst_n pulsed low during HEADER → all outputs at reset values. After release, a queued flit is served normally starting from port 0 priority.

Source files
------------

// File: rtl/router_controller_np_if.sv
// Router controller port bundle: input FIFO pop side, output FIFO write side,
// and controller status outputs.
// master: the controller (drives pops, writes and status).
// slave:  the FIFO/datapath side (drives empty/full flags and read data).
interface router_controller_np_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 64
);
  localparam int PW = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]        in_empty;
  logic [NUM_PORTS-1:0]        in_rd;
  logic [NUM_PORTS*DATA_W-1:0] in_data;
  logic [NUM_PORTS-1:0]        out_full;
  logic [NUM_PORTS-1:0]        out_we;
  logic [DATA_W-1:0]           out_data;
  logic [PW-1:0]               grant_port;
  logic                        busy;
  logic                        pkt_dropped;
  logic [15:0]                 drop_count;

  modport master (
    input  in_empty, in_data, out_full,
    output in_rd, out_we, out_data, grant_port, busy, pkt_dropped, drop_count
  );

  modport slave (
    output in_empty, in_data, out_full,
    input  in_rd, out_we, out_data, grant_port, busy, pkt_dropped, drop_count
  );
endinterface

// File: rtl/router_controller_np.sv
// Round-robin N-port flit router: pops one flit, routes/forwards/drops it by header.
// Latency: IDLE -> READ (in_rd) -> HEADER -> WRITE (out_we); 3 cycles/flit sustained.
// Backpressure: WRITE stalls all-or-nothing while any targeted out_full is set.
// Ports: clk, rst_n (async active-low); bus (master modport) carries in_empty/in_rd/
// in_data, out_full/out_we/out_data, and grant_port/busy/pkt_dropped/drop_count.
module router_controller_np #(
  parameter int AURORA_DATA_WIDTH      = 64,
  parameter int NUM_PORTS              = 4,
  parameter int RECOGNIZE_ROUTER_WIDTH = 2,
  parameter int ROUTER_ID              = 0,
  parameter int TTL_LSB                = 7,
  parameter int DST_LSB                = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  router_controller_np_if.master bus
);
  localparam int W  = AURORA_DATA_WIDTH;
  localparam int RW = RECOGNIZE_ROUTER_WIDTH;
  localparam int PW = $clog2(NUM_PORTS);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_READ   = 2'd1;
  localparam logic [1:0] ST_HEADER = 2'd2;
  localparam logic [1:0] ST_WRITE  = 2'd3;

  logic [1:0]           state;
  logic [PW-1:0]        grant_q;
  logic [PW-1:0]        last_grant;
  logic [W-1:0]         word_q;
  logic [NUM_PORTS-1:0] mask_q;
  logic [15:0]          drop_cnt_q;

  // Round-robin search. In WRITE the pointer that will be committed this cycle
  // is the current grant, so the search uses it directly to allow a back-to-back
  // READ without an IDLE bubble.
  logic [PW-1:0] rr_base;
  logic [PW-1:0] rr_idx;
  logic          rr_vld;
  int            cand;

  always_comb begin
    rr_base = (state == ST_WRITE) ? grant_q : last_grant;
    rr_vld  = 1'b0;
    rr_idx  = '0;
    cand    = 0;
    // Walk from farthest to nearest so the nearest non-empty port wins.
    for (int i = NUM_PORTS; i >= 1; i--) begin
      cand = (int'(rr_base) + i) % NUM_PORTS;
      if (!bus.in_empty[cand]) begin
        rr_vld = 1'b1;
        rr_idx = PW'(cand);
      end
    end
  end

  // Header decode on the FIFO read data of the granted port (valid in HEADER).
  logic [W-1:0]         hdr;
  logic [W-1:0]         hdr_mod;
  logic [1:0]           ttl;
  logic [RW-1:0]        dst;
  logic [NUM_PORTS-1:0] fwd_mask;
  logic [NUM_PORTS-1:0] hdr_mask;
  logic                 hdr_drop;

  always_comb begin
    hdr = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_q == PW'(p)) hdr = bus.in_data[p*W +: W];
    end
    ttl = hdr[TTL_LSB +: 2];
    dst = hdr[DST_LSB +: RW];

    // Forward to every link except the one the flit came in on.
    fwd_mask          = '1;
    fwd_mask[0]       = 1'b0;
    fwd_mask[grant_q] = 1'b0;

    hdr_mod  = hdr;
    hdr_mask = '0;
    if (dst == RW'(ROUTER_ID)) begin
      // Local delivery; local-port ingress addressed to us is an illegal loopback.
      if (grant_q != '0) hdr_mask = {{(NUM_PORTS-1){1'b0}}, 1'b1};
    end else if (ttl > 2'd1) begin
      hdr_mask              = fwd_mask;
      hdr_mod[TTL_LSB +: 2] = ttl - 2'd1;
    end
  end

  // An empty mask covers every drop case, including the degenerate 2-port forward.
  assign hdr_drop = (hdr_mask == '0);

  logic wr_ok;
  assign wr_ok = ((mask_q & bus.out_full) == '0);

  logic [NUM_PORTS-1:0] rd_onehot;
  always_comb begin
    rd_onehot          = '0;
    rd_onehot[grant_q] = 1'b1;
  end

  assign bus.in_rd       = (state == ST_READ) ? rd_onehot : '0;
  assign bus.out_we      = (state == ST_WRITE && wr_ok) ? mask_q : '0;
  assign bus.out_data    = word_q;
  assign bus.grant_port  = grant_q;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.pkt_dropped = (state == ST_HEADER) && hdr_drop;
  assign bus.drop_count  = drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant_q    <= '0;
      last_grant <= PW'(NUM_PORTS - 1);
      word_q     <= '0;
      mask_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rr_vld) begin
            grant_q <= rr_idx;
            state   <= ST_READ;
          end
        end
        ST_READ: begin
          state <= ST_HEADER;
        end
        ST_HEADER: begin
          if (hdr_drop) begin
            if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            last_grant <= grant_q;
            state      <= ST_IDLE;
          end else begin
            word_q <= hdr_mod;
            mask_q <= hdr_mask;
            state  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (wr_ok) begin
            last_grant <= grant_q;
            if (rr_vld) begin
              grant_q <= rr_idx;
              state   <= ST_READ;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_router_controller_np.sv
module tb_router_controller_np;
  localparam int N = 4;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  router_controller_np_if #(.NUM_PORTS(N), .DATA_W(W)) bus();

  router_controller_np #(
    .AURORA_DATA_WIDTH(W), .NUM_PORTS(N), .RECOGNIZE_ROUTER_WIDTH(2),
    .ROUTER_ID(0), .TTL_LSB(7), .DST_LSB(9)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Environment: input FIFOs as queues, output full flags as a driven vector.
  logic [W-1:0] fq [N][$];
  logic [N-1:0] empty_drv, full_drv, rd_prev;
  logic         rst_val;
  int           push_pct;
  bit           full_rand;

  int checks, errors, cyc;

  // Reference model: flit lifecycle (age 0 = pop cycle, 1 = decode, 2+ = write attempts).
  int           m_ptr, m_cnt, next_port, fl_port, fl_age;
  logic [N-1:0] m_mask;
  logic [W-1:0] m_word;

  // Event logs for the directed literal checks.
  logic [N-1:0] last_rd, last_we;
  logic [W-1:0] last_we_dat;
  int           last_rd_cyc, last_we_cyc, last_drop_cyc;
  int           we_events, drop_events;
  int           rd_log[$], rd_cyc_log[$];

  task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int rr(int base, logic [N-1:0] empty);
    for (int i = 1; i <= N; i++)
      if (!empty[(base + i) % N]) return (base + i) % N;
    return -1;
  endfunction

  // Routing rules for ROUTER_ID=0, TTL at [8:7], destination at [10:9].
  function automatic void route(input int port, input logic [W-1:0] w,
                                output logic [N-1:0] mask, output logic [W-1:0] nw);
    int ttl;
    int dst;
    ttl  = int'(w[8:7]);
    dst  = int'(w[10:9]);
    nw   = w;
    mask = '0;
    if (dst == 0) begin
      if (port != 0) mask = 4'b0001;
    end else if (ttl > 1) begin
      mask       = 4'b1111;
      mask[0]    = 1'b0;
      mask[port] = 1'b0;
      nw[8:7]    = 2'(ttl - 1);
    end
  endfunction

  function automatic logic [W-1:0] mk_flit(int dst, int ttl);
    logic [W-1:0] f;
    f       = {$urandom, $urandom};
    f[8:7]  = 2'(ttl);
    f[10:9] = 2'(dst);
    return f;
  endfunction

  task automatic model_reset();
    m_ptr = N - 1; m_cnt = 0; next_port = -1; fl_port = -1; fl_age = 0;
  endtask

  task automatic check();
    logic [N-1:0] e_rd, e_we;
    bit e_drop, arb;
    int w;
    if (bus.in_rd != '0) begin
      last_rd = bus.in_rd; last_rd_cyc = cyc;
      for (int p = 0; p < N; p++) if (bus.in_rd[p]) rd_log.push_back(p);
      rd_cyc_log.push_back(cyc);
    end
    if (bus.out_we != '0) begin
      last_we = bus.out_we; last_we_cyc = cyc; last_we_dat = bus.out_data; we_events++;
    end
    if (bus.pkt_dropped) begin drop_events++; last_drop_cyc = cyc; end

    if (!rst_n) begin
      cmp("rst_in_rd", bus.in_rd, 0);
      cmp("rst_out_we", bus.out_we, 0);
      cmp("rst_out_data", bus.out_data, 0);
      cmp("rst_grant", bus.grant_port, 0);
      cmp("rst_busy", bus.busy, 0);
      cmp("rst_dropped", bus.pkt_dropped, 0);
      cmp("rst_drop_count", bus.drop_count, 0);
      model_reset();
      return;
    end

    if (fl_port >= 0) fl_age++;
    if (next_port >= 0) begin
      fl_port = next_port; next_port = -1; fl_age = 0;
      if (fq[fl_port].size() == 0) cmp("model_pop_nonempty", 0, 1);
      else route(fl_port, fq[fl_port][0], m_mask, m_word);
    end

    cmp("busy", bus.busy, fl_port >= 0);
    cmp("drop_count", bus.drop_count, m_cnt);
    e_rd = '0; e_we = '0; e_drop = 0; arb = (fl_port < 0);
    if (fl_port >= 0) begin
      cmp("grant_port", bus.grant_port, fl_port);
      if (fl_age == 0) begin
        e_rd[fl_port] = 1'b1;
      end else if (fl_age == 1) begin
        e_drop = (m_mask == '0);
        if (e_drop) begin
          if (m_cnt < 65535) m_cnt++;
          m_ptr = fl_port; fl_port = -1;
        end
      end else begin
        cmp("out_data", bus.out_data, m_word);
        if ((m_mask & full_drv) == '0) begin
          e_we = m_mask; m_ptr = fl_port; fl_port = -1; arb = 1;
        end
      end
    end
    cmp("in_rd", bus.in_rd, e_rd);
    cmp("out_we", bus.out_we, e_we);
    cmp("pkt_dropped", bus.pkt_dropped, e_drop);
    if (arb) begin
      w = rr(m_ptr, empty_drv);
      if (w >= 0) next_port = w;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rst_n = rst_val;
    for (int p = 0; p < N; p++)
      if (rd_prev[p] && fq[p].size() > 0) bus.in_data[p*W +: W] = fq[p].pop_front();
    for (int p = 0; p < N; p++)
      if (push_pct > 0 && $urandom_range(99) < push_pct && fq[p].size() < 8)
        fq[p].push_back(mk_flit($urandom_range(3), $urandom_range(3)));
    if (full_rand)
      for (int p = 0; p < N; p++) full_drv[p] = ($urandom_range(3) == 0);
    bus.out_full = full_drv;
    for (int p = 0; p < N; p++) empty_drv[p] = (fq[p].size() == 0);
    bus.in_empty = empty_drv;
    @(negedge clk);
    cyc++;
    check();
    rd_prev = bus.in_rd;
  endtask

  function automatic bit all_drained();
    for (int p = 0; p < N; p++) if (fq[p].size() != 0) return 0;
    return (fl_port < 0) && (next_port < 0);
  endfunction

  task automatic run_until_idle(int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (all_drained()) return;
      step();
    end
    cmp("drain_timeout", 1, 0);
  endtask

  logic [W-1:0] f, e;
  int s, we0, d0;

  initial begin
    checks = 0; errors = 0; cyc = 0;
    push_pct = 0; full_rand = 0; full_drv = '0; rd_prev = '0; rst_val = 1'b0;
    we_events = 0; drop_events = 0; last_rd = '0; last_we = '0; last_we_dat = '0;
    last_rd_cyc = 0; last_we_cyc = 0; last_drop_cyc = 0;
    bus.in_empty = '1; bus.out_full = '0; bus.in_data = '0; empty_drv = '1;
    model_reset();

    repeat (3) step();
    rst_val = 1'b1;
    repeat (2) step();

    // Local delivery from port 2.
    f = mk_flit(0, 2); fq[2].push_back(f); s = cyc + 1; we0 = we_events;
    run_until_idle(50);
    cmp("t1_rd_vec", last_rd, 4'b0100);
    cmp("t1_rd_cyc", last_rd_cyc, s + 1);
    cmp("t1_we_vec", last_we, 4'b0001);
    cmp("t1_we_cyc", last_we_cyc, s + 3);
    cmp("t1_data", last_we_dat, f);
    cmp("t1_we_count", we_events - we0, 1);

    // Forward from local port with TTL decrement.
    f = mk_flit(3, 3); fq[0].push_back(f);
    run_until_idle(50);
    e = f; e[8:7] = 2'b10;
    cmp("t2_we_vec", last_we, 4'b1110);
    cmp("t2_data", last_we_dat, e);

    // TTL expiry drops.
    we0 = we_events; d0 = drop_events; s = cyc + 1;
    fq[1].push_back(mk_flit(2, 1));
    run_until_idle(50);
    repeat (2) step();
    cmp("t3_drop_cyc", last_drop_cyc, s + 2);
    cmp("t3_drop_count1", bus.drop_count, 1);
    fq[1].push_back(mk_flit(2, 0));
    run_until_idle(50);
    repeat (2) step();
    cmp("t3_drop_count2", bus.drop_count, 2);
    cmp("t3_drop_pulses", drop_events - d0, 2);
    cmp("t3_no_writes", we_events - we0, 0);

    // Round-robin order and back-to-back service from reset.
    rst_val = 1'b0; step();
    for (int k = 0; k < 2; k++) begin
      fq[0].push_back(mk_flit(1, 3));
      fq[1].push_back(mk_flit(1, 3));
      fq[3].push_back(mk_flit(1, 3));
    end
    step();
    rd_log.delete(); rd_cyc_log.delete();
    rst_val = 1'b1;
    run_until_idle(200);
    cmp("t4_reads", rd_log.size(), 6);
    if (rd_log.size() >= 4) begin
      cmp("t4_order0", rd_log[0], 0);
      cmp("t4_order1", rd_log[1], 1);
      cmp("t4_order2", rd_log[2], 3);
      cmp("t4_order3", rd_log[3], 0);
      for (int k = 1; k < 4; k++) cmp("t4_gap", rd_cyc_log[k] - rd_cyc_log[k-1], 3);
    end

    // Stall on a full target for five WRITE cycles.
    we0 = we_events;
    fq[1].push_back(mk_flit(3, 3)); full_drv = 4'b0100;
    step(); step();
    repeat (6) step();
    full_drv = '0;
    run_until_idle(50);
    cmp("t5_we_vec", last_we, 4'b1100);
    cmp("t5_latency", last_we_cyc - last_rd_cyc, 7);
    cmp("t5_we_count", we_events - we0, 1);

    // Reset during HEADER; queued flits then served from port-0 priority.
    we0 = we_events;
    fq[2].push_back(mk_flit(1, 3));
    step(); step();
    fq[1].push_back(mk_flit(1, 3)); fq[3].push_back(mk_flit(1, 3));
    rst_val = 1'b0; step();
    cmp("t6_busy", bus.busy, 0);
    cmp("t6_grant", bus.grant_port, 0);
    cmp("t6_drop_count", bus.drop_count, 0);
    rd_log.delete(); rd_cyc_log.delete();
    rst_val = 1'b1;
    run_until_idle(100);
    cmp("t6_reads", rd_log.size(), 2);
    if (rd_log.size() >= 2) begin
      cmp("t6_first", rd_log[0], 1);
      cmp("t6_second", rd_log[1], 3);
    end
    cmp("t6_writes", we_events - we0, 2);

    // Randomized traffic with random backpressure and one mid-run reset.
    we0 = we_events; d0 = drop_events;
    push_pct = 30; full_rand = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) rst_val = 1'b0;
      if (i == 2002) rst_val = 1'b1;
      step();
    end
    push_pct = 0; full_rand = 0; full_drv = '0;
    run_until_idle(600);
    cmp("rand_writes_seen", (we_events - we0) > 100, 1);
    cmp("rand_drops_seen", (drop_events - d0) > 10, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
